// File: rtl/excitation_source_if.sv
// Source-to-filter bundle: sequencer parameters in, excitation sample and filter handshake out.
interface excitation_source_if;
   logic        enable;
   logic [7:0]  period;
   logic [7:0]  amp;
   logic        params_load;
   logic [15:0] src_out;
   logic        filter_start;
   logic        filter_done;
   logic        busy;
   logic        overrun;

   modport master (
      input  enable, period, amp, params_load, filter_done,
      output src_out, filter_start, busy, overrun
   );

   modport slave (
      output enable, period, amp, params_load, filter_done,
      input  src_out, filter_start, busy, overrun
   );
endinterface

// File: rtl/excitation_source.sv
// Excitation generator: glottal pulse train or LFSR noise, one sample per tick, handed to the filter.
// Optional EXCITE_OVERRUN_EN adds a sticky flag for ticks dropped while a sample is in flight.
module excitation_source #(
   parameter int unsigned CLK_DIV   = 1000,
   parameter logic [16:0] LFSR_SEED = 17'h00001
) (
   input logic                 clk,
   input logic                 rst,
   excitation_source_if.master bus
);
   localparam int unsigned DIV_W  = 16;
   localparam int unsigned SMP_W  = 16;
   localparam int unsigned LFSR_W = 17;
   localparam int unsigned PAR_W  = 8;

   typedef struct packed {
      logic [PAR_W-1:0] period;
      logic [PAR_W-1:0] amp;
   } params_t;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_START, S_WAIT} state_t;

   state_t            state_q;
   logic [DIV_W-1:0]  div_q;
   logic [PAR_W-1:0]  pitch_q;
   logic [LFSR_W-1:0] lfsr_q;
   params_t           shadow_q;
   params_t           active_q;
   logic [SMP_W-1:0]  src_q;
   logic              start_q;
   logic              busy_q;

   logic              tick_c;
   logic              boundary_c;
   params_t           eff_c;
   logic [LFSR_W-1:0] lfsr_d;
   logic [SMP_W-1:0]  noise_mag_c;
   logic [SMP_W-1:0]  src_d;
   logic [PAR_W-1:0]  pitch_d;

   // Sample-rate divider; enable low parks it at zero.
   assign tick_c = bus.enable && (div_q == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else if (!bus.enable || tick_c) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // Next sample; at a boundary the shadow parameters are used directly since they become active now.
   always_comb begin
      boundary_c  = (pitch_q == '0);
      eff_c       = boundary_c ? shadow_q : active_q;
      lfsr_d      = {lfsr_q[LFSR_W-2:0], lfsr_q[16] ^ lfsr_q[13]};
      noise_mag_c = {6'b0, eff_c.amp, 2'b0};
      src_d       = '0;
      pitch_d     = '0;
      if (eff_c.period != '0) begin
         src_d   = boundary_c ? {4'b0, eff_c.amp, 4'b0} : '0;
         pitch_d = boundary_c ? eff_c.period - PAR_W'(1) : pitch_q - PAR_W'(1);
      end else begin
         src_d   = lfsr_d[0] ? noise_mag_c : (~noise_mag_c + SMP_W'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pitch_q  <= '0;
         lfsr_q   <= LFSR_SEED;
         shadow_q <= '0;
         active_q <= '0;
         src_q    <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         if (bus.params_load) begin
            shadow_q <= params_t'({bus.period, bus.amp});
         end
         case (state_q)
            S_IDLE: begin
               if (tick_c) begin
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               if (boundary_c) begin
                  active_q <= shadow_q;
               end
               if (eff_c.period == '0) begin
                  lfsr_q <= lfsr_d;
               end
               src_q   <= src_d;
               pitch_q <= pitch_d;
               start_q <= 1'b1;
               busy_q  <= 1'b1;
               state_q <= S_START;
            end
            S_START: begin
               start_q <= 1'b0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.filter_done) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.src_out      = src_q;
   assign bus.filter_start = start_q;
   assign bus.busy         = busy_q;

`ifdef EXCITE_OVERRUN_EN
   logic overrun_q;

   // Any tick seen outside IDLE is lost; remember it until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (tick_c && (state_q != S_IDLE)) begin
         overrun_q <= 1'b1;
      end
   end

   assign bus.overrun = overrun_q;
`else
   assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_excitation_source.sv
// Directed bench for excitation_source: reset, voiced train, parameter timing, noise, overrun, async reset.
module tb_excitation_source;
   localparam int unsigned CLK_DIV = 8;

`ifdef EXCITE_OVERRUN_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   excitation_source_if ex_if();

   excitation_source #(.CLK_DIV(CLK_DIV), .LFSR_SEED(17'h00001)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ex_if.master)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic done_q    = 1'b0;
   logic hold_done = 1'b0;
   int   done_cnt  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Filter model: done rises 3 cycles after start and stays high until the next start.
   always @(posedge clk) begin
      if (ex_if.filter_start === 1'b1) begin
         done_q   <= 1'b0;
         done_cnt <= 2;
      end else if (done_cnt != 0) begin
         done_cnt <= done_cnt - 1;
         if (done_cnt == 1) done_q <= 1'b1;
      end
   end

   assign ex_if.filter_done = done_q & ~hold_done;

   task automatic wait_start(output bit ok, output logic [15:0] val, output int at);
      ok  = 1'b0;
      val = 16'hxxxx;
      at  = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ex_if.filter_start === 1'b1) begin
            ok  = 1'b1;
            val = ex_if.src_out;
            at  = cyc;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      ex_if.enable      = 1'b0;
      ex_if.params_load = 1'b0;
      rst               = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load(input logic [7:0] p, input logic [7:0] a);
      @(negedge clk);
      ex_if.period      = p;
      ex_if.amp         = a;
      ex_if.params_load = 1'b1;
      @(negedge clk);
      ex_if.params_load = 1'b0;
   endtask

   task automatic test_reset();
      bit ok; logic [15:0] v; int at; int c0; bit early;
      ex_if.period = 8'h00; ex_if.amp = 8'h00; ex_if.params_load = 1'b0;
      ex_if.enable = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (ex_if.src_out !== 16'h0000) begin fails++; $display("FAIL reset_src_out got %h expected 0000", ex_if.src_out); end
      tests++; if (ex_if.filter_start !== 1'b0) begin fails++; $display("FAIL reset_filter_start got %b expected 0", ex_if.filter_start); end
      tests++; if (ex_if.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", ex_if.busy); end
      tests++; if (ex_if.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b expected 0", ex_if.overrun); end
      rst = 1'b0;
      c0 = cyc;
      early = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (ex_if.filter_start !== 1'b0) early = 1'b1;
      end
      tests++; if (early !== 1'b0) begin fails++; $display("FAIL reset_no_early_start got %b expected 0", early); end
      wait_start(ok, v, at);
      tests++;
      if (!ok) begin fails++; $display("FAIL reset_first_start got timeout expected start"); end
      else if (at - c0 != 9) begin fails++; $display("FAIL reset_first_start_latency got %0d expected 9", at - c0); end
      tests++; if (ok && v !== 16'h0000) begin fails++; $display("FAIL reset_first_sample got %h expected 0000", v); end
   endtask

   task automatic test_voiced();
      bit ok; logic [15:0] v; logic [15:0] exp; int at; int prev;
      do_reset();
      load(8'd4, 8'h10);
      ex_if.enable = 1'b1;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         wait_start(ok, v, at);
         tests++;
         if (!ok) begin fails++; $display("FAIL voiced_timeout sample %0d got none expected start", i); break; end
         exp = (i % 4 == 0) ? 16'h0100 : 16'h0000;
         if (v !== exp) begin fails++; $display("FAIL voiced_sample %0d got %h expected %h", i, v, exp); end
         if (i == 0) begin
            tests++; if (ex_if.busy !== 1'b1) begin fails++; $display("FAIL voiced_busy got %b expected 1", ex_if.busy); end
         end else begin
            tests++; if (at - prev != 8) begin fails++; $display("FAIL voiced_spacing %0d got %0d expected 8", i, at - prev); end
         end
         prev = at;
      end
   endtask

   task automatic test_param_timing();
      bit ok; logic [15:0] v; int at;
      logic [15:0] exp [9] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0200,
                               16'h0000, 16'h0200, 16'h0000, 16'h0200};
      do_reset();
      load(8'd4, 8'h10);
      ex_if.enable = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wait_start(ok, v, at);
         tests++;
         if (!ok) begin fails++; $display("FAIL param_timeout sample %0d got none expected start", i); break; end
         if (v !== exp[i]) begin fails++; $display("FAIL param_sample %0d got %h expected %h", i, v, exp[i]); end
         if (i == 1) load(8'd2, 8'h20);
      end
   endtask

   task automatic test_noise();
      bit ok; logic [15:0] v; logic [15:0] mag; logic [15:0] exp; int at;
      logic [16:0] m;
      do_reset();
      load(8'd0, 8'h01);
      ex_if.enable = 1'b1;
      m   = 17'h00001;
      mag = {6'b0, 8'h01, 2'b0};
      for (int i = 0; i < 64; i++) begin
         wait_start(ok, v, at);
         tests++;
         if (!ok) begin fails++; $display("FAIL noise_timeout sample %0d got none expected start", i); break; end
         m   = {m[15:0], m[16] ^ m[13]};
         exp = m[0] ? mag : 16'(~mag + 16'd1);
         if (v !== exp) begin fails++; $display("FAIL noise_sample %0d got %h expected %h", i, v, exp); end
         if (i == 0) begin
            tests++; if (v !== 16'hFFFC) begin fails++; $display("FAIL noise_first got %h expected fffc", v); end
         end
      end
   endtask

   task automatic test_overrun();
      bit ok; logic [15:0] v; int at; int at0;
      logic [15:0] exp [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0100};
      do_reset();
      load(8'd4, 8'h10);
      ex_if.enable = 1'b1;
      wait_start(ok, v, at0);
      tests++;
      if (!ok || v !== 16'h0100) begin fails++; $display("FAIL overrun_first got %h expected 0100", v); end
      hold_done = 1'b1;
      repeat (20) @(negedge clk);
      tests++; if (ex_if.busy !== 1'b1) begin fails++; $display("FAIL overrun_busy_held got %b expected 1", ex_if.busy); end
      tests++; if (ex_if.overrun !== OVR_EXP) begin fails++; $display("FAIL overrun_flag got %b expected %b", ex_if.overrun, OVR_EXP); end
      hold_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_start(ok, v, at);
         tests++;
         if (!ok) begin fails++; $display("FAIL overrun_timeout sample %0d got none expected start", i + 1); break; end
         if (v !== exp[i]) begin fails++; $display("FAIL overrun_sample %0d got %h expected %h", i + 1, v, exp[i]); end
         if (i == 0) begin
            tests++; if (at - at0 != 24) begin fails++; $display("FAIL overrun_resume_gap got %0d expected 24", at - at0); end
         end
      end
   endtask

   task automatic test_async_reset();
      bit ok; logic [15:0] v; int at;
      do_reset();
      load(8'd4, 8'h10);
      ex_if.enable = 1'b1;
      wait_start(ok, v, at);
      tests++;
      if (!ok || v !== 16'h0100) begin fails++; $display("FAIL async_first got %h expected 0100", v); end
      #1 rst = 1'b1;
      #1;
      tests++; if (ex_if.busy !== 1'b0) begin fails++; $display("FAIL async_busy got %b expected 0", ex_if.busy); end
      tests++; if (ex_if.filter_start !== 1'b0) begin fails++; $display("FAIL async_filter_start got %b expected 0", ex_if.filter_start); end
      tests++; if (ex_if.src_out !== 16'h0000) begin fails++; $display("FAIL async_src_out got %h expected 0000", ex_if.src_out); end
      @(negedge clk);
      rst = 1'b0;
      tests++; if (ex_if.overrun !== 1'b0) begin fails++; $display("FAIL async_overrun got %b expected 0", ex_if.overrun); end
      wait_start(ok, v, at);
      tests++;
      if (!ok || v !== 16'h0000) begin fails++; $display("FAIL async_after_reset got %h expected 0000", v); end
      load(8'd4, 8'h10);
      wait_start(ok, v, at);
      tests++;
      if (!ok || v !== 16'h0100) begin fails++; $display("FAIL async_after_load got %h expected 0100", v); end
   endtask

   initial begin
      ex_if.enable      = 1'b0;
      ex_if.period      = 8'h00;
      ex_if.amp         = 8'h00;
      ex_if.params_load = 1'b0;
      test_reset();
      test_voiced();
      test_param_timing();
      test_noise();
      test_overrun();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
